// File: rtl/mdu_issue_ctrl_if.sv
// mdu_issue_ctrl_if: pipeline request/response plus MDU command/status bundle.
// slave = issue controller view, master = pipeline and MDU side.
interface mdu_issue_ctrl_if;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic [31:0] mf_data;
  logic        mdu_start;
  logic [2:0]  mdu_op;
  logic [31:0] mdu_a;
  logic [31:0] mdu_b;
  logic        mdu_busy;
  logic [31:0] mdu_hi;
  logic [31:0] mdu_lo;

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    output req_ready,
    output mf_data,
    output mdu_start,
    output mdu_op,
    output mdu_a,
    output mdu_b,
    input  mdu_busy,
    input  mdu_hi,
    input  mdu_lo
  );

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    input  req_ready,
    input  mf_data,
    input  mdu_start,
    input  mdu_op,
    input  mdu_a,
    input  mdu_b,
    output mdu_busy,
    output mdu_hi,
    output mdu_lo
  );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl: E-stage launcher for the multiply/divide unit.
// Optional watchdog on ARM+RUN enabled by defining MDU_TIMEOUT_EN.
module mdu_issue_ctrl
`ifdef MDU_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYC = 32)
`endif
  (
  input  logic            clk,
  input  logic            reset,
  mdu_issue_ctrl_if.slave bus,
  output logic            mdu_pending,
  output logic            mdu_err
);

  // MDUOp encodings shared with the MDU.
  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    ARM,
    RUN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic        is_md;
  logic        is_mthi;
  logic        is_mtlo;
  logic        is_mfhi;
  logic        is_mflo;
  logic        to_fire;

  function automatic logic [2:0] md_code(input logic [1:0] k);
    logic [2:0] c;
    unique case (k)
      2'd0: c = MDU_MULT;
      2'd1: c = MDU_MULTU;
      2'd2: c = MDU_DIV;
      2'd3: c = MDU_DIVU;
    endcase
    return c;
  endfunction

  // Classify the instruction presented by the pipeline.
  always_comb begin
    is_md   = 1'b0;
    is_mthi = 1'b0;
    is_mtlo = 1'b0;
    is_mfhi = 1'b0;
    is_mflo = 1'b0;
    if (bus.req_valid) begin
      unique case (1'b1)
        (bus.req_op[3:2] == 2'b00): is_md   = 1'b1;
        (bus.req_op == 4'd4):       is_mthi = 1'b1;
        (bus.req_op == 4'd5):       is_mtlo = 1'b1;
        (bus.req_op == 4'd6):       is_mfhi = 1'b1;
        (bus.req_op == 4'd7):       is_mflo = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef MDU_TIMEOUT_EN
  logic [5:0] cnt_q;
  logic [5:0] cnt_inc;

  assign cnt_inc = cnt_q + 6'd1;
  assign to_fire = ((state == ARM) || (state == RUN)) &&
                   (cnt_inc == 6'(TIMEOUT_CYC));

  // Watchdog: count cycles spent waiting on the MDU.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == LAUNCH) begin
      cnt_q <= '0;
    end else if ((state == ARM) || (state == RUN)) begin
      cnt_q <= cnt_inc;
    end
  end

  // Sticky error once the watchdog abandons an operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdu_err <= 1'b0;
    end else if (to_fire) begin
      mdu_err <= 1'b1;
    end
  end
`else
  assign to_fire = 1'b0;
  assign mdu_err = 1'b0;
`endif

  // Capture operands of a multiply/divide when it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if ((state == IDLE) && is_md) begin
      op_q <= bus.req_op[1:0];
      a_q  <= bus.req_a;
      b_q  <= bus.req_b;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and MDU/pipeline outputs.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = 1'b0;
    bus.mf_data   = '0;
    bus.mdu_start = 1'b0;
    bus.mdu_op    = MDU_NOP;
    bus.mdu_a     = a_q;
    bus.mdu_b     = b_q;
    unique case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (is_md) begin
          state_nxt = LAUNCH;
        end
        if (is_mthi) begin
          bus.mdu_op = MDU_MTHI;
          bus.mdu_a  = bus.req_a;
        end
        if (is_mtlo) begin
          bus.mdu_op = MDU_MTLO;
          bus.mdu_a  = bus.req_a;
        end
        if (is_mfhi) begin
          bus.mf_data = bus.mdu_hi;
        end
        if (is_mflo) begin
          bus.mf_data = bus.mdu_lo;
        end
      end
      LAUNCH: begin
        bus.mdu_start = 1'b1;
        bus.mdu_op    = md_code(op_q);
        state_nxt     = ARM;
      end
      ARM: begin
        if (to_fire) begin
          state_nxt = IDLE;
        end else if (bus.mdu_busy) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!bus.mdu_busy || to_fire) begin
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign mdu_pending = (state != IDLE);

endmodule
